// File: rtl/myproject_div_pkg.sv
// myproject_div_pkg: shared state encoding and default widths for the sequential signed divider.
package myproject_div_pkg;

    localparam int DIN0_W = 27;
    localparam int DIN1_W = 6;
    localparam int DOUT_W = 21;
    localparam int CNT_W  = $clog2(DIN0_W);
    localparam int REM_W  = DIN1_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/myproject_sdiv_27s_6ns_21_seq_step.sv
// myproject_div_step: one combinational restoring-division iteration.
module myproject_div_step
    import myproject_div_pkg::*;
#(
    parameter int din1_WIDTH = DIN1_W
) (
    input  logic [din1_WIDTH:0]   partial,
    input  logic                  dividend_bit,
    input  logic [din1_WIDTH-1:0] divisor,
    output logic [din1_WIDTH:0]   partial_next,
    output logic                  q_bit
);

    logic [din1_WIDTH:0] shifted;

    always_comb begin
        shifted      = {partial[din1_WIDTH-1:0], dividend_bit};
        q_bit        = shifted >= {1'b0, divisor};
        partial_next = q_bit ? shifted - {1'b0, divisor} : shifted;
    end

endmodule

// File: rtl/myproject_sdiv_27s_6ns_21_seq.sv
// myproject_sdiv_27s_6ns_21_seq: fixed-latency signed-by-unsigned restoring divider, one bit per clock.
module myproject_sdiv_27s_6ns_21_seq
    import myproject_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH:0]   rem,
    output logic                  div_zero
);

    localparam int cnt_w = $clog2(din0_WIDTH);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(din0_WIDTH - 1 + 0 * ID);

    state_t state, state_next;
    logic [cnt_w-1:0]      cnt;
    logic                  sign, dz, q_bit, accept;
    logic [din0_WIDTH-1:0] mag, q_signed;
    logic [din1_WIDTH-1:0] divisor;
    logic [din1_WIDTH:0]   partial, partial_next, r_signed;

    myproject_div_step #(.din1_WIDTH(din1_WIDTH)) u_step (
        .partial      (partial),
        .dividend_bit (mag[din0_WIDTH-1]),
        .divisor      (divisor),
        .partial_next (partial_next),
        .q_bit        (q_bit)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ap_ready   = state == IDLE;
        accept     = ap_start && ap_ready;
        q_signed   = sign ? -mag : mag;
        r_signed   = sign ? -partial : partial;
        if (accept)
            state_next = CALC;
        else if (state == CALC && cnt == '0)
            state_next = DONE;
        else if (state == DONE)
            state_next = IDLE;
    end

    // mag doubles as the quotient register: dividend bits shift out the top as quotient bits shift in below.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt      <= '0;
            sign     <= 1'b0;
            dz       <= 1'b0;
            mag      <= '0;
            divisor  <= '0;
            partial  <= '0;
            ap_done  <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            if (accept) begin
                sign    <= din0[din0_WIDTH-1];
                mag     <= din0[din0_WIDTH-1] ? -din0 : din0;
                divisor <= din1;
                dz      <= din1 == '0;
                partial <= '0;
                cnt     <= cnt_last;
            end
            if (state == CALC) begin
                partial <= partial_next;
                mag     <= {mag[din0_WIDTH-2:0], q_bit};
                cnt     <= cnt == '0 ? cnt : cnt - 1'b1;
            end
            if (state == DONE) begin
                quot     <= dz ? '0 : q_signed[dout_WIDTH-1:0];
                rem      <= dz ? '0 : r_signed;
                div_zero <= dz;
                ap_done  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/myproject_sdiv_27s_6ns_21_seq.md
# myproject_sdiv_27s_6ns_21_seq

Sequential signed-by-unsigned integer divider for the quantized LeNet-5 datapath. It undoes the fixed-point scaling introduced by the `myproject_mul_*` product stage: a signed wide product is divided by a small unsigned scale factor, producing a narrower signed quotient and a remainder. It uses one restoring-division bit per clock behind an `ap_start`/`ap_ready`/`ap_done` handshake, and its latency is constant so the HLS scheduler can treat it as a fixed-latency multicycle operator.

## Interface
- `ID`, 1, instance tag, no functional effect
- `din0_WIDTH`, 27, signed dividend width
- `din1_WIDTH`, 6, unsigned divisor width
- `dout_WIDTH`, 21, signed quotient width
- `ap_clk` in 1: the single clock, rising edge.
- `ap_rst` in 1: reset, synchronous and active-high.
- `ap_start` in 1: request. A transfer is accepted on a rising edge where `ap_start && ap_ready`.
- `ap_ready` out 1: high only in IDLE.
- `din0` in din0_WIDTH: signed dividend, sampled at accept.
- `din1` in din1_WIDTH: unsigned divisor, sampled at accept.
- `ap_done` out 1: one-cycle pulse when a result is valid.
- `quot` out dout_WIDTH: signed quotient, held until the next `ap_done`.
- `rem` out din1_WIDTH+1: signed remainder, held until the next `ap_done`.
- `div_zero` out 1: result flag, `din1==0`. Updated together with `quot`/`rem`.

## Operation
- States:
  - IDLE → CALC on accept.
  - CALC runs exactly din0_WIDTH iterations (counter counts din0_WIDTH-1 down to 0), then → DONE.
  - DONE → IDLE unconditionally.
- At accept the block registers:
  - sign = din0[MSB]
  - mag = |din0| as a din0_WIDTH-bit unsigned value. −2^26 gives mag = 2^26, with no overflow.
  - divisor = din1
  - dz = (din1 == 0)
- Each CALC cycle performs one restoring step:
  - partial = {partial[din1_WIDTH-1:0], mag[MSB]}, where partial is din1_WIDTH+1 bits.
  - Shift mag left.
  - If partial ≥ divisor: subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
- DONE registers the outputs:
  - quot = low dout_WIDTH bits of (sign ? −q : q). This is two's-complement wrap, matching a C cast; there is no saturation.
  - rem = sign ? −r : r. The quotient truncates toward zero and the remainder takes the dividend's sign.
  - div_zero = dz.
  - `ap_done` = 1.
- Divide by zero: the block still runs all CALC cycles (latency stays constant). In DONE it forces quot = 0, rem = 0, div_zero = 1.
- `ap_start` in CALC or DONE is ignored. No queueing; the requester holds `ap_start` until it sees `ap_ready`.
- `ap_start` held high continuously: a new accept occurs in the IDLE cycle that follows each DONE.
- Inputs are sampled only at accept; changes to `din0`/`din1` during CALC have no effect.

## Timing
- Reset values: state = IDLE, `ap_ready` = 1, `ap_done` = 0, `quot` = 0, `rem` = 0, `div_zero` = 0, counter = 0.
- Accept at edge E0. `ap_done` is high for exactly one cycle after edge E0 + din0_WIDTH + 1, which is 28 edges with the default widths.
- `ap_ready` is low from E0 through the DONE cycle and high again after the next edge.
- Throughput: one division per din0_WIDTH + 2 cycles (29 with defaults).
- `ap_rst` asserted mid-operation: on that edge all state returns to the reset values. The in-flight result is discarded and no `ap_done` is produced. The outputs read 0.
- `ap_rst` and `ap_start` high on the same edge: reset wins and nothing is accepted.

## Structure
- Package `myproject_div_pkg` holds:
  - the state enum (IDLE, CALC, DONE)
  - localparams for the counter width, clog2(din0_WIDTH)
  - localparams for the remainder width, din1_WIDTH+1
- Sub-module `myproject_div_step`: a combinational single restoring iteration.
  - Inputs: partial, next dividend bit, divisor.
  - Outputs: new partial, quotient bit.
  - Instantiated once; the top-level FSM owns all registers.

## Test plan
- din0 = 100, din1 = 7 → quot = 14, rem = 2, div_zero = 0; `ap_done` pulses 28 edges after accept.
- din0 = −100, din1 = 7 → quot = −14, rem = −2.
- din0 = 2^26−1, din1 = 63 → quot = −1031932 (1065220 wrapped to 21 bits), rem = 3.
- din0 = −2^26, din1 = 1 → quot = 0 (wrapped), rem = 0. din0 = 5, din1 = 0 → quot = 0, rem = 0, div_zero = 1, with the same 28-edge latency.
- Reset edge 10 cycles after accept:
  - the next cycle has `ap_ready` = 1 and all outputs 0;
  - no `ap_done` appears.
  - A fresh accept of 100/7 then completes normally.
- `ap_start` held high with alternating operands, and din0 changed during CALC:
  - `ap_done` arrives every 29 cycles;
  - each result matches the operands sampled at its accept.
